// File: rtl/sw_debounce_pkg.sv
// Shared board constants for the switch-conditioning stage in front of the adder.
package sw_debounce_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
    localparam int SIM_DEBOUNCE_CYCLES     = 4;
    localparam int SW_COUNT                = 4;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10
    } edge_e;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch: 2-flop synchronizer, stability counter, debounced level and edge strobes.
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
)(
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic sw_db,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_reg;
    logic             s2_reg;
    logic             db_reg;
    logic             db_next;
    logic             rise_reg;
    logic             fall_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    edge_e            edge_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg   <= 1'b0;
            s2_reg   <= 1'b0;
            cnt_reg  <= '0;
            db_reg   <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            s1_reg   <= sw;
            s2_reg   <= s1_reg;
            cnt_reg  <= cnt_next;
            db_reg   <= db_next;
            rise_reg <= (edge_next == EDGE_RISE);
            fall_reg <= (edge_next == EDGE_FALL);
        end
    end

    // Any sample agreeing with the accepted level discards the whole run.
    always_comb begin
        cnt_next  = cnt_reg;
        db_next   = db_reg;
        edge_next = EDGE_NONE;
        if (s2_reg == db_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
            cnt_next  = '0;
            db_next   = s2_reg;
            edge_next = s2_reg ? EDGE_RISE : EDGE_FALL;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    assign sw_db = db_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/sw_debounce.sv
// WIDTH independent debounced switches feeding the adder operands, plus a common change strobe.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH           = SW_COUNT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] SW_DB,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic             CHANGED
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            sw_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_bit (
                .clk   (CLK),
                .rst   (RST),
                .sw    (SW[gi]),
                .sw_db (SW_DB[gi]),
                .rise  (RISE[gi]),
                .fall  (FALL[gi])
            );
        end
    endgenerate

    // OR of registered strobes only, so no path from SW reaches CHANGED.
    assign CHANGED = |(RISE | FALL);

endmodule

// File: tb/tb_sw_debounce.sv
// Directed plus random bench for sw_debounce, checked against a sample-history reference model.
module tb_sw_debounce;
    import sw_debounce_pkg::*;

    localparam int W = 4;
    localparam int N = SIM_DEBOUNCE_CYCLES;

    logic         CLK;
    logic         RST;
    logic [W-1:0] SW;
    logic [W-1:0] SW_DB;
    logic [W-1:0] RISE;
    logic [W-1:0] FALL;
    logic         CHANGED;

    int n_checks = 0;
    int n_err    = 0;

    sw_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SW      (SW),
        .SW_DB   (SW_DB),
        .RISE    (RISE),
        .FALL    (FALL),
        .CHANGED (CHANGED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: raw samples, the value seen two edges later, and the edge of each bit's last acceptance.
    logic [W-1:0] samp_q[$];
    logic [W-1:0] cmp_q[$];
    int           last_acc[W];
    logic [W-1:0] db_m;
    logic [W-1:0] rise_m;
    logic [W-1:0] fall_m;

    task automatic model_reset();
        samp_q.delete();
        samp_q.push_back('0);
        samp_q.push_back('0);
        cmp_q.delete();
        for (int i = 0; i < W; i++) last_acc[i] = -1;
        db_m   = '0;
        rise_m = '0;
        fall_m = '0;
    endtask

    // A bit is accepted when the last N delayed samples since its previous acceptance all disagree with it.
    task automatic model_edge(input logic [W-1:0] sw_now);
        logic [W-1:0] cmp;
        int           k;
        cmp = samp_q[samp_q.size()-2];
        samp_q.push_back(sw_now);
        cmp_q.push_back(cmp);
        k = cmp_q.size() - 1;
        rise_m = '0;
        fall_m = '0;
        for (int i = 0; i < W; i++) begin
            bit ok;
            ok = 1'b1;
            for (int j = 0; j < N; j++) begin
                int idx;
                idx = k - j;
                if (idx <= last_acc[i]) ok = 1'b0;
                else if (cmp_q[idx][i] == db_m[i]) ok = 1'b0;
            end
            if (ok) begin
                last_acc[i] = k;
                db_m[i]     = cmp[i];
                if (cmp[i]) rise_m[i] = 1'b1;
                else        fall_m[i] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("sw_db",   SW_DB, db_m);
        chk("rise",    RISE,  rise_m);
        chk("fall",    FALL,  fall_m);
        chk("changed", {3'b000, CHANGED}, {3'b000, |(rise_m | fall_m)});
    endtask

    // Drive at the falling edge, update the model at the rising edge, compare at the next falling edge.
    task automatic step(input logic [W-1:0] v);
        SW = v;
        @(posedge CLK);
        if (!RST) model_edge(v);
        @(negedge CLK);
        $display("t=%0t rst=%b sw=%b sw_db=%b rise=%b fall=%b changed=%b",
                 $time, RST, SW, SW_DB, RISE, FALL, CHANGED);
        check_all();
    endtask

    initial begin
        logic [W-1:0] sw_r;
        logic         bseq[6];

        // Reset held with all switches high
        RST = 1'b1;
        SW  = 4'b1111;
        model_reset();
        for (int e = 0; e < 3; e++) begin
            step(4'b1111);
            chk("rst_hold_db", SW_DB, 4'b0000);
            chk("rst_hold_strobe", RISE | FALL | {3'b000, CHANGED}, 4'b0000);
        end
        RST = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step(4'b1111);
            chk("rel_rise", RISE, (e == 6) ? 4'b1111 : 4'b0000);
            chk("rel_chg", {3'b000, CHANGED}, (e == 6) ? 4'b0001 : 4'b0000);
        end

        // Settle low, then clean step on bit 0
        for (int e = 0; e < 8; e++) step(4'b0000);
        for (int e = 0; e < 8; e++) begin
            step(4'b0001);
            chk("clean_rise", RISE, (e == 5) ? 4'b0001 : 4'b0000);
            chk("clean_nofall", FALL, 4'b0000);
        end
        for (int e = 0; e < 8; e++) begin
            step(4'b0000);
            chk("clean_fall", FALL, (e == 5) ? 4'b0001 : 4'b0000);
        end

        // Glitch rejection on bit 2: short pulses rejected, long one accepted
        for (int e = 0; e < 3; e++) step(4'b0100);
        for (int e = 0; e < 8; e++) begin
            step(4'b0000);
            chk("glitch3_db", SW_DB, 4'b0000);
            chk("glitch3_chg", {3'b000, CHANGED}, 4'b0000);
        end
        for (int e = 0; e < 2; e++) step(4'b0100);
        for (int e = 0; e < 8; e++) begin
            step(4'b0000);
            chk("glitch2_db", SW_DB, 4'b0000);
        end
        for (int e = 0; e < 8; e++) begin
            step(4'b0100);
            chk("long_rise", RISE, (e == 5) ? 4'b0100 : 4'b0000);
        end

        // Bounce train on bit 1; last 0->1 sample lands on index 5
        bseq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int e = 0; e < 14; e++) begin
            step({1'b0, 1'b1, (e < 6) ? bseq[e] : 1'b1, 1'b0});
            chk("bounce_rise", RISE, (e == 10) ? 4'b0010 : 4'b0000);
        end

        // Simultaneous change on bits 0 and 2
        for (int e = 0; e < 8; e++) step(4'b0000);
        for (int e = 0; e < 8; e++) begin
            step(4'b0101);
            chk("simul_rise", RISE, (e == 5) ? 4'b0101 : 4'b0000);
            chk("simul_chg", {3'b000, CHANGED}, (e == 5) ? 4'b0001 : 4'b0000);
        end

        // Reset two counts into a bit-3 excursion, asserted between clock edges
        for (int e = 0; e < 4; e++) step(4'b1101);
        #2 RST = 1'b1;
        #1;
        model_reset();
        chk("async_db", SW_DB, 4'b0000);
        chk("async_strobe", RISE | FALL | {3'b000, CHANGED}, 4'b0000);
        step(4'b1101);
        step(4'b1101);
        RST = 1'b0;
        for (int e = 0; e < 8; e++) begin
            step(4'b1101);
            chk("rerel_rise", RISE, (e == 5) ? 4'b1101 : 4'b0000);
        end

        // Random bouncing on all bits
        sw_r = 4'b1101;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(5) == 0) sw_r[i] = ~sw_r[i];
            step(sw_r);
        end
        for (int e = 0; e < 8; e++) step(sw_r);
        chk("final_db", SW_DB, sw_r);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
